riscv_branch_predictor: RTL
===========================

Name: riscv_branch_predictor

Overview:
Parametrised branch resolution and prediction unit for the RISC-V cores. It resolves all six conditional branch types (beq, bne, blt, bge, bltu, bgeu) on XLEN-wide operands. It also keeps a direct-mapped branch target table with saturating counters, so the fetch stage can predict branch outcome and target. Lookup sits beside the PC register; resolve/update is driven from the execute stage, and resolution results are registered for the PC-select path.

Parameters:
XLEN, 32, datapath/PC width in bits (>= 16)
ENTRIES, 16, table entries; power of two, >= 2; IDX_W = log2(ENTRIES)
CNT_W, 2, saturating counter width (>= 1)
STAT_W, 32, width of the statistics counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
lk_pc  in  XLEN  fetch PC to look up
lk_hit  out  1  combinational: entry valid and tag match
lk_taken  out  1  combinational: lk_hit && counter MSB
lk_target  out  XLEN  combinational: stored target; 0 when !lk_hit
upd_valid  in  1  a branch resolves this cycle
upd_pc  in  XLEN  PC of the resolving branch
upd_funct3  in  3  branch funct3
upd_rs1  in  XLEN  operand 1
upd_rs2  in  XLEN  operand 2
upd_target  in  XLEN  computed branch target (pc + imm)
upd_pred_taken  in  1  prediction used at fetch for this branch
upd_pred_target  in  XLEN  predicted target used at fetch
res_valid  out  1  registered: resolution valid
res_taken  out  1  registered: actual outcome
res_mispredict  out  1  registered: redirect required
res_redirect_pc  out  XLEN  registered: correct next PC
res_illegal  out  1  registered: funct3 was 010 or 011
stat_branches  out  STAT_W  resolved legal branches, saturating
stat_mispredicts  out  STAT_W  mispredicts, saturating

Behaviour:
- Index = pc[IDX_W+1:2]. Tag = pc[XLEN-1:IDX_W+2]. Each entry holds valid, tag, target[XLEN], cnt[CNT_W].
- Reset (rst=0, asynchronous): all valid bits, counters, and targets cleared; res_* = 0; stat_* = 0. Lookup outputs reflect the empty table (hit=0, taken=0, target=0). Reset in the middle of an update discards that update.
- Compare (combinational, on upd_*): 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge. 010/011 are illegal: actual taken = 0, no table update, no stat update, res_illegal = 1.
- Mispredict = actual != upd_pred_taken, OR (actual && upd_pred_taken && upd_pred_target != upd_target). An illegal funct3 forces mispredict = 0.
- Redirect PC = actual ? upd_target : upd_pc + 4 (wraps modulo 2^XLEN).
- Latency: res_* update on the rising edge after upd_valid, so they are valid for exactly one cycle. When upd_valid = 0 at an edge, res_valid = 0 and the other res_* fields hold their previous values.
- Table update on the edge where upd_valid = 1 and funct3 is legal:
  - Hit and taken: cnt = min(cnt+1, max); target = upd_target.
  - Hit and not taken: cnt = max(cnt-1, 0); target unchanged.
  - Miss and taken: allocate the entry (overwriting any occupant): valid = 1, tag, target, cnt = 2^(CNT_W-1) (weakly taken).
  - Miss and not taken: no change.
- Simultaneous lookup and update on the same index: the lookup returns pre-update contents; the new value is visible from the next cycle.
- Stats: stat_branches += 1 per legal resolve; stat_mispredicts += 1 per mispredict. Both saturate at all-ones and never wrap.

Test Plan:
- Reset, then lk_pc=0x10 -> lk_hit=0, lk_taken=0, lk_target=0. All res_* = 0 and stat_* = 0.
- Resolve bltu: rs1=10, rs2=0xffff0000, pc=0, target=16, pred_taken=0 -> next cycle res_valid=1, res_taken=1, res_mispredict=1, redirect=16. After the edge, lk_pc=0 gives hit=1, taken=1, target=16.
- Same pc resolved three times not-taken (rs1=20, rs2=10, funct3=110) -> counter goes 2→1→0→0. lk_taken drops to 0 after the first update; redirect=4; stat_branches=4.
- Signed vs unsigned: rs1=0xffffffff, rs2=1 -> blt taken, bltu not taken, bge not taken, bgeu taken.
- Aliasing: pc=0x0 taken, then pc=0x40 taken (ENTRIES=16, same index) -> pc=0x40 replaces the entry; lk_pc=0 now misses.
- Illegal funct3=010 -> res_illegal=1, res_mispredict=0, table and stats unchanged. Preload stat_mispredicts to all-ones, then force a mispredict -> it stays all-ones.

Source files
------------

// File: rtl/riscv_branch_predictor.sv
// Branch resolution and prediction unit: resolves the six conditional branch
// types, keeps a direct-mapped target table with saturating counters for the
// fetch stage, registers the resolution result for PC select, and counts
// resolved branches and mispredicts.
module riscv_branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   lk_pc,
    output logic              lk_hit,
    output logic              lk_taken,
    output logic [XLEN-1:0]   lk_target,
    input  logic              upd_valid,
    input  logic [XLEN-1:0]   upd_pc,
    input  logic [2:0]        upd_funct3,
    input  logic [XLEN-1:0]   upd_rs1,
    input  logic [XLEN-1:0]   upd_rs2,
    input  logic [XLEN-1:0]   upd_target,
    input  logic              upd_pred_taken,
    input  logic [XLEN-1:0]   upd_pred_target,
    output logic              res_valid,
    output logic              res_taken,
    output logic              res_mispredict,
    output logic [XLEN-1:0]   res_redirect_pc,
    output logic              res_illegal,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(1) << (CNT_W - 1);

    logic             valid_reg  [ENTRIES];
    logic [TAG_W-1:0] tag_reg    [ENTRIES];
    logic [XLEN-1:0]  target_reg [ENTRIES];
    logic [CNT_W-1:0] cnt_reg    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             upd_illegal;
    logic             actual_taken;
    logic             mispredict;
    logic             table_we;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] cnt_cur;
    logic [CNT_W-1:0] cnt_next;

    // Instructions are word aligned, so the two low PC bits carry no information.
    logic unused_lk_bits;
    assign unused_lk_bits = ^lk_pc[1:0];

    assign lk_idx  = lk_pc[IDX_W+1:2];
    assign lk_tag  = lk_pc[XLEN-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[XLEN-1:IDX_W+2];

    // Fetch-side lookup: reads current (pre-update) table contents.
    always_comb begin
        lk_hit    = valid_reg[lk_idx] && (tag_reg[lk_idx] == lk_tag);
        lk_taken  = lk_hit && cnt_reg[lk_idx][CNT_W-1];
        lk_target = lk_hit ? target_reg[lk_idx] : '0;
    end

    // Branch condition evaluation; funct3 010/011 are not branches.
    always_comb begin
        actual_taken = 1'b0;
        upd_illegal  = 1'b0;
        case (upd_funct3)
            3'b000:  actual_taken = (upd_rs1 == upd_rs2);
            3'b001:  actual_taken = (upd_rs1 != upd_rs2);
            3'b100:  actual_taken = ($signed(upd_rs1) <  $signed(upd_rs2));
            3'b101:  actual_taken = ($signed(upd_rs1) >= $signed(upd_rs2));
            3'b110:  actual_taken = (upd_rs1 <  upd_rs2);
            3'b111:  actual_taken = (upd_rs1 >= upd_rs2);
            default: upd_illegal  = 1'b1;
        endcase
    end

    // Mispredict detection, redirect target and next counter value.
    always_comb begin
        mispredict = !upd_illegal &&
                     ((actual_taken != upd_pred_taken) ||
                      (actual_taken && upd_pred_taken && (upd_pred_target != upd_target)));
        redirect_pc = actual_taken ? upd_target : upd_pc + XLEN'(4);
        upd_hit     = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);
        table_we    = upd_valid && !upd_illegal;
        cnt_cur     = cnt_reg[upd_idx];
        cnt_next    = cnt_cur;
        if (actual_taken) begin
            if (cnt_cur != CNT_MAX) cnt_next = cnt_cur + CNT_W'(1);
        end else begin
            if (cnt_cur != '0) cnt_next = cnt_cur - CNT_W'(1);
        end
    end

    // Table update: train on a hit, allocate on a taken miss.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_reg[i]  <= 1'b0;
                tag_reg[i]    <= '0;
                target_reg[i] <= '0;
                cnt_reg[i]    <= '0;
            end
        end else if (table_we) begin
            if (upd_hit) begin
                cnt_reg[upd_idx] <= cnt_next;
                if (actual_taken) target_reg[upd_idx] <= upd_target;
            end else if (actual_taken) begin
                valid_reg[upd_idx]  <= 1'b1;
                tag_reg[upd_idx]    <= upd_tag;
                target_reg[upd_idx] <= upd_target;
                cnt_reg[upd_idx]    <= CNT_INIT;
            end
        end
    end

    // Registered resolution result; fields hold when no branch resolves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid       <= 1'b0;
            res_taken       <= 1'b0;
            res_mispredict  <= 1'b0;
            res_redirect_pc <= '0;
            res_illegal     <= 1'b0;
        end else begin
            res_valid <= upd_valid;
            if (upd_valid) begin
                res_taken       <= actual_taken;
                res_mispredict  <= mispredict;
                res_redirect_pc <= redirect_pc;
                res_illegal     <= upd_illegal;
            end
        end
    end

    // Saturating statistics counters over legal resolves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (table_we) begin
            if (stat_branches != '1) stat_branches <= stat_branches + STAT_W'(1);
            if (mispredict && (stat_mispredicts != '1))
                stat_mispredicts <= stat_mispredicts + STAT_W'(1);
        end
    end

endmodule
